fwd_hazard_unit: RTL and testbench

Parametrised forwarding and hazard unit for the in-order pipeline, replacing the fixed two-stage combinational forwarding detector. It keeps its own shift register of destination tags for instructions that have left ID. From these tags it selects a forwarding source for each source operand in ID, and it raises a load-use stall when a load result is not yet forwardable. It sits beside the ID stage. Its outputs drive the ID/EX operand muxes, the PC and IF/ID write enables, and the ID/EX bubble insert.

---
 rtl/fwd_hazard_unit.sv | 89 ++++++++
 tb/tb_fwd_hazard_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard detection beside the ID stage.
// Keeps a private shift register of destination tags for instructions that have left ID.
module fwd_hazard_unit #(
  parameter int DEPTH      = 2,
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = $clog2(DEPTH + 1),
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_is_load,
  input  logic             flush,
  output logic [SEL_W-1:0] forward_rs1,
  output logic [SEL_W-1:0] forward_rs2,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  logic [DEPTH:1] tag_valid;
  logic [DEPTH:1] tag_wr;
  logic [DEPTH:1] tag_load;
  logic [4:0]     tag_rd [1:DEPTH];

  int   stage_rs1;
  int   stage_rs2;
  logic load_rs1;
  logic load_rs2;
  logic hazard;
  logic fwd_en;
  logic capture;

  // Scan oldest to youngest so the youngest matching producer is the last assignment.
  always_comb begin
    stage_rs1 = 0;
    stage_rs2 = 0;
    load_rs1  = 1'b0;
    load_rs2  = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (id_use_rs1 && id_rs1 != 5'd0 && tag_valid[k] && tag_wr[k] && tag_rd[k] == id_rs1) begin
        stage_rs1 = k;
        load_rs1  = tag_load[k];
      end
      if (id_use_rs2 && id_rs2 != 5'd0 && tag_valid[k] && tag_wr[k] && tag_rd[k] == id_rs2) begin
        stage_rs2 = k;
        load_rs2  = tag_load[k];
      end
    end
  end

  assign hazard  = (load_rs1 && stage_rs1 < LOAD_READY) || (load_rs2 && stage_rs2 < LOAD_READY);
  assign stall   = id_valid & ~flush & hazard;
  assign fwd_en  = id_valid & ~flush & ~hazard;
  assign capture = fwd_en;

  assign forward_rs1 = fwd_en ? SEL_W'(stage_rs1) : '0;
  assign forward_rs2 = fwd_en ? SEL_W'(stage_rs2) : '0;

  // Tags advance every cycle regardless of stall; a stall only freezes IF/ID.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_valid   <= '0;
      tag_wr      <= '0;
      tag_load    <= '0;
      for (int k = 1; k <= DEPTH; k++) tag_rd[k] <= '0;
      stall_count <= '0;
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_wr[k]    <= tag_wr[k-1];
        tag_load[k]  <= tag_load[k-1];
        tag_rd[k]    <= tag_rd[k-1];
      end
      tag_valid[1] <= capture;
      tag_wr[1]    <= capture & id_reg_write;
      tag_load[1]  <= capture & id_is_load;
      tag_rd[1]    <= capture ? id_rd : 5'd0;
      if (stall && stall_count != '1)
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: default configuration plus DEPTH=4, LOAD_READY=3.
module tb_fwd_hazard_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       a_valid, a_use1, a_use2, a_rw, a_ld, a_fl;
  logic [4:0] a_rs1, a_rs2, a_rd;
  logic [1:0] a_f1, a_f2;
  logic       a_stall;
  logic [31:0] a_cnt;

  logic       b_valid, b_use1, b_use2, b_rw, b_ld, b_fl;
  logic [4:0] b_rs1, b_rs2, b_rd;
  logic [2:0] b_f1, b_f2;
  logic       b_stall;
  logic [31:0] b_cnt;

  fwd_hazard_unit dut_a (
    .clk(clk), .reset(reset), .id_valid(a_valid), .id_rs1(a_rs1), .id_rs2(a_rs2),
    .id_use_rs1(a_use1), .id_use_rs2(a_use2), .id_rd(a_rd), .id_reg_write(a_rw),
    .id_is_load(a_ld), .flush(a_fl), .forward_rs1(a_f1), .forward_rs2(a_f2),
    .stall(a_stall), .stall_count(a_cnt)
  );

  fwd_hazard_unit #(.DEPTH(4), .LOAD_READY(3)) dut_b (
    .clk(clk), .reset(reset), .id_valid(b_valid), .id_rs1(b_rs1), .id_rs2(b_rs2),
    .id_use_rs1(b_use1), .id_use_rs2(b_use2), .id_rd(b_rd), .id_reg_write(b_rw),
    .id_is_load(b_ld), .flush(b_fl), .forward_rs1(b_f1), .forward_rs2(b_f2),
    .stall(b_stall), .stall_count(b_cnt)
  );

  typedef struct {
    string       tag;
    int          dut;
    logic [2:0]  f1;
    logic [2:0]  f2;
    logic        st;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check_out();
    exp_t e;
    logic [2:0]  o_f1, o_f2;
    logic        o_st;
    logic [31:0] o_cnt;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty observed=0 entries required=1");
      return;
    end
    e = sb.pop_front();
    o_f1  = (e.dut == 0) ? {1'b0, a_f1} : b_f1;
    o_f2  = (e.dut == 0) ? {1'b0, a_f2} : b_f2;
    o_st  = (e.dut == 0) ? a_stall : b_stall;
    o_cnt = (e.dut == 0) ? a_cnt : b_cnt;
    checks++;
    assert (o_f1 === e.f1) else begin
      errors++; $error("FAIL %s forward_rs1 observed=%0d expected=%0d", e.tag, o_f1, e.f1);
    end
    checks++;
    assert (o_f2 === e.f2) else begin
      errors++; $error("FAIL %s forward_rs2 observed=%0d expected=%0d", e.tag, o_f2, e.f2);
    end
    checks++;
    assert (o_st === e.st) else begin
      errors++; $error("FAIL %s stall observed=%0b expected=%0b", e.tag, o_st, e.st);
    end
    checks++;
    assert (o_cnt === e.cnt) else begin
      errors++; $error("FAIL %s stall_count observed=%0d expected=%0d", e.tag, o_cnt, e.cnt);
    end
  endtask

  // mode 0: check at negedge then advance; 1: check at negedge only; 2: check after #1 only
  task automatic step(input string tag, input int d, input logic v,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic rw, input logic ld, input logic fl,
                      input logic [2:0] ef1, input logic [2:0] ef2, input logic est,
                      input logic [31:0] ecnt, input int mode);
    exp_t e;
    {a_valid, a_rs1, a_rs2, a_use1, a_use2, a_rd, a_rw, a_ld, a_fl} = '0;
    {b_valid, b_rs1, b_rs2, b_use1, b_use2, b_rd, b_rw, b_ld, b_fl} = '0;
    if (d == 0) begin
      a_valid = v; a_rs1 = rs1; a_rs2 = rs2; a_use1 = u1; a_use2 = u2;
      a_rd = rd; a_rw = rw; a_ld = ld; a_fl = fl;
    end else begin
      b_valid = v; b_rs1 = rs1; b_rs2 = rs2; b_use1 = u1; b_use2 = u2;
      b_rd = rd; b_rw = rw; b_ld = ld; b_fl = fl;
    end
    e.tag = tag; e.dut = d; e.f1 = ef1; e.f2 = ef2; e.st = est; e.cnt = ecnt;
    sb.push_back(e);
    if (mode == 2) #1;
    else @(negedge clk);
    check_out();
    if (mode == 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    step("rst_a", 0, 1, 5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 0, 0, 0, 0, 0, 1);
    step("rst_b", 1, 1, 5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 0, 0, 0, 0, 0, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    step("alu_prod",   0, 1, 5'd1,  5'd2,  1, 1, 5'd5,  1, 0, 0, 0, 0, 0, 0, 0);
    step("alu_b2b",    0, 1, 5'd5,  5'd5,  1, 1, 5'd6,  1, 0, 0, 1, 1, 0, 0, 0);
    step("indep",      0, 1, 5'd8,  5'd9,  1, 1, 5'd11, 1, 0, 0, 0, 0, 0, 0, 0);
    step("gap_fwd2",   0, 1, 5'd6,  5'd5,  1, 1, 5'd12, 1, 0, 0, 2, 0, 0, 0, 0);
    step("lw7",        0, 1, 5'd1,  5'd0,  1, 0, 5'd7,  1, 1, 0, 0, 0, 0, 0, 0);
    step("lu_stall",   0, 1, 5'd7,  5'd7,  1, 1, 5'd13, 1, 0, 0, 0, 0, 1, 0, 0);
    step("lu_fwd",     0, 1, 5'd7,  5'd7,  1, 1, 5'd13, 1, 0, 0, 2, 2, 0, 1, 0);
    step("x3_a",       0, 1, 5'd4,  5'd0,  1, 0, 5'd3,  1, 0, 0, 0, 0, 0, 1, 0);
    step("x3_b",       0, 1, 5'd4,  5'd0,  1, 0, 5'd3,  1, 0, 0, 0, 0, 0, 1, 0);
    step("youngest",   0, 1, 5'd3,  5'd0,  1, 1, 5'd0,  1, 0, 0, 1, 0, 0, 1, 0);
    step("x0_src",     0, 1, 5'd0,  5'd3,  1, 1, 5'd14, 1, 0, 0, 0, 2, 0, 1, 0);
    step("no_use",     0, 1, 5'd14, 5'd14, 1, 0, 5'd15, 1, 0, 0, 1, 0, 0, 1, 0);
    step("lw8",        0, 1, 5'd0,  5'd0,  0, 0, 5'd8,  1, 1, 0, 0, 0, 0, 1, 0);
    step("flush_haz",  0, 1, 5'd8,  5'd0,  1, 0, 5'd16, 1, 0, 1, 0, 0, 0, 1, 0);
    step("post_flush", 0, 1, 5'd8,  5'd16, 1, 1, 5'd18, 1, 0, 0, 2, 0, 0, 1, 0);
    step("lw9",        0, 1, 5'd0,  5'd0,  0, 0, 5'd9,  1, 1, 0, 0, 0, 0, 1, 0);
    step("mid_stall",  0, 1, 5'd9,  5'd0,  1, 0, 5'd17, 1, 0, 0, 0, 0, 1, 1, 1);
    #2 reset = 1'b1;
    step("rst_mid",    0, 1, 5'd9,  5'd0,  1, 0, 5'd17, 1, 0, 0, 0, 0, 0, 0, 2);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    step("post_rst",   0, 1, 5'd9,  5'd17, 1, 1, 5'd19, 1, 0, 0, 0, 1, 0, 0, 0);

    step("b_lw",       1, 1, 5'd1,  5'd0,  1, 0, 5'd7,  1, 1, 0, 0, 0, 0, 0, 0);
    step("b_stall1",   1, 1, 5'd7,  5'd0,  1, 0, 5'd20, 1, 0, 0, 0, 0, 1, 0, 0);
    step("b_stall2",   1, 1, 5'd7,  5'd0,  1, 0, 5'd20, 1, 0, 0, 0, 0, 1, 1, 0);
    step("b_fwd3",     1, 1, 5'd7,  5'd0,  1, 0, 5'd20, 1, 0, 0, 3, 0, 0, 2, 0);
    step("b_wr21",     1, 1, 5'd1,  5'd0,  1, 0, 5'd21, 1, 0, 0, 0, 0, 0, 2, 0);
    step("b_ind22",    1, 1, 5'd1,  5'd0,  1, 0, 5'd22, 1, 0, 0, 0, 0, 0, 2, 0);
    step("b_ind23",    1, 1, 5'd1,  5'd0,  1, 0, 5'd23, 1, 0, 0, 0, 0, 0, 2, 0);
    step("b_ind24",    1, 1, 5'd1,  5'd0,  1, 0, 5'd24, 1, 0, 0, 0, 0, 0, 2, 0);
    step("b_fwd4",     1, 1, 5'd21, 5'd20, 1, 1, 5'd25, 1, 0, 0, 4, 0, 0, 2, 0);
    step("b_gone",     1, 1, 5'd21, 5'd0,  1, 0, 5'd26, 1, 0, 0, 0, 0, 0, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
